// File: rtl/arb_pkg.sv
// Shared types and width helpers for the arbiter requester endpoint.
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        XFER
    } arb_req_state_e;

    // Bits needed to hold values 0..n-1, never less than one.
    function automatic int cw(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/arb_req_fifo.sv
// Circular word buffer with occupancy count and full/empty flags.
module arb_req_fifo
    import arb_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       enq,
    input  logic                       deq,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);

    localparam int PW = cw(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd;
    logic [PW-1:0]    wr;
    logic             do_enq;
    logic             do_deq;

    assign full   = (count == CW'(DEPTH));
    assign empty  = (count == '0);
    assign do_enq = enq & ~full;
    assign do_deq = deq & ~empty;
    assign rdata  = mem[rd];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd    <= '0;
            wr    <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_enq) begin
                mem[wr] <= wdata;
                wr      <= wr + 1'b1;
            end
            if (do_deq) begin
                rd <= rd + 1'b1;
            end
            if (do_enq && !do_deq) begin
                count <= count + 1'b1;
            end else if (!do_enq && do_deq) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/arb_requester.sv
// Arbiter client: buffers words, requests the bus, streams bounded bursts
// while granted and flags starvation on long-unanswered requests.
module arb_requester
    import arb_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int DEPTH        = 4,
    parameter int MAX_BURST    = 4,
    parameter int STARVE_LIMIT = 15
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       io_enq_valid,
    output logic                       io_enq_ready,
    input  logic [WIDTH-1:0]           io_enq_bits,
    output logic                       io_request,
    input  logic                       io_grant,
    output logic                       io_bus_valid,
    output logic [WIDTH-1:0]           io_bus_bits,
    output logic                       io_bus_last,
    output logic                       io_starved,
    output logic [$clog2(DEPTH+1)-1:0] io_count
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int BW = cw(MAX_BURST);
    localparam int SW = cw(STARVE_LIMIT + 1);

    arb_req_state_e state;
    logic [BW-1:0]  beat;
    logic [SW-1:0]  starve;
    logic           live;
    logic           full;
    logic           empty;
    logic           enq;

    // Ready is held low through reset and goes high on the first edge after.
    assign io_enq_ready = live & ~full;
    assign enq          = io_enq_valid & io_enq_ready;
    assign io_request   = (state != IDLE);
    assign io_bus_valid = (state == XFER) & io_grant;
    assign io_bus_last  = io_bus_valid &
                          ((io_count == CW'(1)) ||
                           (beat == BW'(MAX_BURST - 1)));
    assign io_starved   = (starve == SW'(STARVE_LIMIT));

    arb_req_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .enq   (enq),
        .deq   (io_bus_valid),
        .wdata (io_enq_bits),
        .rdata (io_bus_bits),
        .count (io_count),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            beat   <= '0;
            starve <= '0;
            live   <= 1'b0;
        end else begin
            live <= 1'b1;
            unique case (state)
                IDLE: begin
                    if (!empty) begin
                        state <= REQ;
                    end
                end
                REQ: begin
                    if (io_grant) begin
                        state  <= XFER;
                        starve <= '0;
                    end else if (!io_starved) begin
                        starve <= starve + 1'b1;
                    end
                end
                XFER: begin
                    // Preemption keeps the unsent words and re-requests.
                    if (!io_grant) begin
                        state <= REQ;
                        beat  <= '0;
                    end else if (io_bus_last) begin
                        state <= IDLE;
                        beat  <= '0;
                    end else begin
                        beat <= beat + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
